// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for the async FIFO: write address/strobe, Gray write pointer, full/occupancy flags.
// Optional almost-full flag built only when ASYNC_FIFO_ALMOST_FULL_EN is defined.
module fifo_wptr_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned AFULL_THRESH = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic [ADDR_WIDTH:0]   wcount,
    output logic                  walmost_full,
    output logic                  woverflow
);
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_wptr_ctrl: AFULL_THRESH out of range 1..DEPTH");
    end

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wcount_q, wcount_d;
    logic          wfull_q, wfull_d;
    logic          woverflow_q, woverflow_d;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] rptr_full_cmp;

    assign wen   = winc & ~wfull_q & ~rst;
    assign waddr = wbin_q[ADDR_WIDTH-1:0];

    always_comb begin
        rbin_sync = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            rbin_sync[i] = ^(wq2_rptr >> i);
        end
    end

    // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
    assign rptr_full_cmp = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};

    always_comb begin
        wbin_d      = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
        wptr_d      = (wbin_d >> 1) ^ wbin_d;
        wcount_d    = wbin_d - rbin_sync;
        wfull_d     = (wptr_d == rptr_full_cmp);
        woverflow_d = woverflow_q | (winc & wfull_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_q      <= '0;
            wptr_q      <= '0;
            wcount_q    <= '0;
            wfull_q     <= 1'b0;
            woverflow_q <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            wptr_q      <= wptr_d;
            wcount_q    <= wcount_d;
            wfull_q     <= wfull_d;
            woverflow_q <= woverflow_d;
        end
    end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    localparam logic [PW-1:0] AFULL_THRESH_W = PW'(AFULL_THRESH);

    logic walmost_full_q, walmost_full_d;

    always_comb begin
        walmost_full_d = (wcount_d >= AFULL_THRESH_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            walmost_full_q <= 1'b0;
        end else begin
            walmost_full_q <= walmost_full_d;
        end
    end

    assign walmost_full = walmost_full_q;
`else
    assign walmost_full = 1'b0;
`endif

    assign wptr      = wptr_q;
    assign wcount    = wcount_q;
    assign wfull     = wfull_q;
    assign woverflow = woverflow_q;

endmodule

// File: doc/fifo_wptr_ctrl.md
# fifo_wptr_ctrl

Write-domain pointer controller for the async FIFO. Sequences writes into the dual-port memory: generates the binary write address and memory strobe, and produces the Gray-coded write pointer handed to the read-domain synchronizer. Derives `wfull`, occupancy and warning flags from the read pointer already synchronized into the write clock domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 6, memory address bits; depth DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `AFULL_THRESH`, 56, occupancy at or above which `walmost_full` asserts; legal range 1..DEPTH.

Ports:
- `clk`  in  1  write-domain clock.
- `rst`  in  1  synchronous, active-high reset.
- `winc`  in  1  write request from producer.
- `wq2_rptr`  in  ADDR_WIDTH+1  Gray read pointer, already synchronized into `clk` domain.
- `wen`  out  1  memory write strobe.
- `waddr`  out  ADDR_WIDTH  memory write address.
- `wptr`  out  ADDR_WIDTH+1  registered Gray write pointer, to read-side synchronizer.
- `wfull`  out  1  FIFO full, registered.
- `wcount`  out  ADDR_WIDTH+1  occupancy seen from write side, registered, 0..DEPTH.
- `walmost_full`  out  1  occupancy ≥ AFULL_THRESH, registered.
- `woverflow`  out  1  sticky: write requested while full.

## Operation
- Internal binary pointer `wbin` (ADDR_WIDTH+1 bits); `waddr = wbin[ADDR_WIDTH-1:0]`.
- `wen = winc & ~wfull & ~rst` (combinational from registered `wfull`).
- `wbin_next = wbin + wen`, modulo 2^(ADDR_WIDTH+1); `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- `rbin_sync` = Gray-to-binary of `wq2_rptr` (XOR prefix from MSB).
- Each edge: `wbin <= wbin_next`; `wptr <= wgray_next`; `wcount <= wbin_next - rbin_sync` (mod 2^(ADDR_WIDTH+1)).
- `wfull <= (wgray_next == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]})`; invariant: `wfull == (wcount == DEPTH)`.
- `woverflow <= woverflow | (winc & wfull)`; cleared only by `rst`.
- Reset (sync, priority over everything): `wbin`, `wptr`, `waddr`, `wcount` = 0; `wfull`, `walmost_full`, `woverflow` = 0; `wen` = 0 while `rst` high.
- Boundaries:
  - Full + `winc`: no write, pointer held, `woverflow` set.
  - Write and read-pointer advance in the same cycle: both reflected in the same `wcount` update; `wfull` not asserted.
  - Pointer wrap 2^(ADDR_WIDTH+1)-1 → 0: no flag glitch; Gray wrap is a single-bit change.
  - `wq2_rptr` never ahead of `wbin` in a legal system; behaviour for illegal input is undefined.

## Timing
- Write accepted in the cycle `wen`=1 at the current `waddr`; `waddr`/`wptr` advance at the following edge.
- `wfull` asserts at the edge that accepts the DEPTH-th outstanding write; `wen` is low from the next cycle.
- Change on `wq2_rptr` → `wfull`/`wcount`/`walmost_full` updated 1 cycle later. Full deassertion is pessimistic by the synchronizer latency; this is intentional.
- Write throughput: 1 per cycle when not full.

## Configuration
- Macro `ASYNC_FIFO_ALMOST_FULL_EN`.
- Defined: `walmost_full <= (wbin_next - rbin_sync) >= AFULL_THRESH`, registered alongside `wcount`.
- Undefined: `walmost_full` tied 0; threshold compare not built; `AFULL_THRESH` ignored.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use ADDR_WIDTH=6, DEPTH=64.
- Reset: `rst`=1 for 2 cycles with `winc`=1 → `wen`=0; all outputs 0.
- Fill: `wq2_rptr`=0, `winc`=1 for 65 cycles → `waddr` 0..63; `wptr` follows 0,1,3,2,6…; after the 64th write `wfull`=1 and `wcount`=64; 65th cycle has `wen`=0 and `woverflow`=1 next edge.
- Almost full: after 56 accepted writes → `walmost_full`=1 with macro, stays 0 without; at 55 writes it is 0.
- Release: from full, set `wq2_rptr`=7'b0000001 → next cycle `wfull`=0 and `wcount`=63; one write at `waddr`=0 → `wfull`=1 again.
- Wrap: `wq2_rptr` tracks `wptr` two cycles late, 200 continuous writes → `wptr` passes 7'b1000000 (gray 127) → 0, `wfull` never asserts, `wcount` ≤ 3.
- Reset mid-operation: at `wcount`=30 with `woverflow`=1, assert `rst` with `winc`=1 → next edge all outputs 0 and no write.
